// File: rtl/issue_queue_pkg.sv
// Shared types and default sizes for the collapsing ALU issue queue.
package issue_queue_pkg;

  localparam int TAG_W       = 6;
  localparam int QUEUE_DEPTH = 4;
  localparam int QUEUE_IDX_W = $clog2(QUEUE_DEPTH);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } issue_state_t;

  typedef logic [QUEUE_IDX_W-1:0] queue_idx_t;

endpackage

// File: rtl/oldest_ready_sel.sv
// Priority encoder: finds the oldest (lowest-index) entry that is both valid and ready.
module oldest_ready_sel #(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0]         ent_valid,
  input  logic [DEPTH-1:0]         ent_ready,
  output logic                     found,
  output logic [$clog2(DEPTH)-1:0] idx
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0] cand;

  // Scan from the top down so the lowest candidate index is the last one written
  always_comb begin
    cand  = ent_valid & ent_ready;
    found = |cand;
    idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (cand[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/alu_queue_ctrl.sv
// Controller for the collapsing ALU issue queue: slot allocation, per-entry
// write strobes with CDB capture, oldest-ready grant and queue collapse.
module alu_queue_ctrl #(
  parameter int DEPTH = issue_queue_pkg::QUEUE_DEPTH,
  parameter int TAG_W = issue_queue_pkg::TAG_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     dispatch_valid,
  input  logic [TAG_W-1:0]         dispatch_op1_tag,
  input  logic [TAG_W-1:0]         dispatch_op2_tag,
  input  logic                     dispatch_op1_valid,
  input  logic                     dispatch_op2_valid,
  output logic                     dispatch_ready,
  input  logic [DEPTH-1:0]         ent_valid,
  input  logic [DEPTH-1:0]         ent_op1_valid,
  input  logic [DEPTH-1:0]         ent_op2_valid,
  input  logic [DEPTH-1:0]         ent_ready,
  input  logic [DEPTH*TAG_W-1:0]   ent_op1_tag,
  input  logic [DEPTH*TAG_W-1:0]   ent_op2_tag,
  input  logic                     cdb_valid,
  input  logic [TAG_W-1:0]         cdb_tag,
  output logic [DEPTH-1:0]         ent_load,
  output logic [DEPTH-1:0]         ent_shift,
  output logic [DEPTH-1:0]         ent_we,
  output logic [DEPTH-1:0]         ent_updt_cmn,
  output logic [DEPTH-1:0]         ent_updt_op1,
  output logic [DEPTH-1:0]         ent_updt_op1_from_cdb,
  output logic [DEPTH-1:0]         ent_updt_op2,
  output logic [DEPTH-1:0]         ent_updt_op2_from_cdb,
  output logic                     issue_valid,
  output logic [$clog2(DEPTH)-1:0] issue_idx,
  input  logic                     issue_ack,
  output logic [$clog2(DEPTH):0]   count
);

  import issue_queue_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  issue_state_t     state_q, state_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic             strobe_en;
  logic             dispatch_fire;
  logic             collapse;
  logic [CNT_W-1:0] wr_idx;

  // "Above" view of the stack; the top entry sees a tied-zero neighbour
  logic [DEPTH-1:0]       above_valid, above_op1_valid, above_op2_valid;
  logic [DEPTH*TAG_W-1:0] above_op1_tag, above_op2_tag;

  logic [DEPTH-1:0] src_valid, src_op1_valid, src_op2_valid;
  logic [TAG_W-1:0] src_op1_tag [DEPTH];
  logic [TAG_W-1:0] src_op2_tag [DEPTH];
  logic [DEPTH-1:0] cdb_hit1, cdb_hit2;

  oldest_ready_sel #(.DEPTH(DEPTH)) u_sel (
    .ent_valid (ent_valid),
    .ent_ready (ent_ready),
    .found     (sel_found),
    .idx       (sel_idx)
  );

  assign issue_valid    = (state_q == GRANT);
  assign issue_idx      = grant_idx_q;
  assign count          = count_q;
  assign dispatch_ready = (count_q < CNT_W'(DEPTH));

  assign above_valid     = {1'b0, ent_valid[DEPTH-1:1]};
  assign above_op1_valid = {1'b0, ent_op1_valid[DEPTH-1:1]};
  assign above_op2_valid = {1'b0, ent_op2_valid[DEPTH-1:1]};
  assign above_op1_tag   = {{TAG_W{1'b0}}, ent_op1_tag[DEPTH*TAG_W-1:TAG_W]};
  assign above_op2_tag   = {{TAG_W{1'b0}}, ent_op2_tag[DEPTH*TAG_W-1:TAG_W]};

  // Handshake qualifiers; reset and flush silence every strobe
  always_comb begin
    strobe_en     = rst & ~flush;
    dispatch_fire = dispatch_valid & dispatch_ready & strobe_en;
    collapse      = issue_valid & issue_ack & strobe_en;
    wr_idx        = count_q - CNT_W'(collapse);
  end

  // Per-entry source select and CDB wakeup on whatever the entry will hold next
  always_comb begin
    ent_load      = '0;
    ent_shift     = '0;
    src_valid     = '0;
    src_op1_valid = '0;
    src_op2_valid = '0;
    cdb_hit1      = '0;
    cdb_hit2      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      src_op1_tag[i] = '0;
      src_op2_tag[i] = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      ent_load[i]  = dispatch_fire && (wr_idx == CNT_W'(i));
      ent_shift[i] = collapse && (CNT_W'(i) >= CNT_W'(grant_idx_q)) && !ent_load[i];
      if (ent_load[i]) begin
        src_valid[i]     = 1'b1;
        src_op1_valid[i] = dispatch_op1_valid;
        src_op2_valid[i] = dispatch_op2_valid;
        src_op1_tag[i]   = dispatch_op1_tag;
        src_op2_tag[i]   = dispatch_op2_tag;
      end else if (ent_shift[i]) begin
        src_valid[i]     = above_valid[i];
        src_op1_valid[i] = above_op1_valid[i];
        src_op2_valid[i] = above_op2_valid[i];
        src_op1_tag[i]   = above_op1_tag[i*TAG_W +: TAG_W];
        src_op2_tag[i]   = above_op2_tag[i*TAG_W +: TAG_W];
      end else begin
        src_valid[i]     = ent_valid[i];
        src_op1_valid[i] = ent_op1_valid[i];
        src_op2_valid[i] = ent_op2_valid[i];
        src_op1_tag[i]   = ent_op1_tag[i*TAG_W +: TAG_W];
        src_op2_tag[i]   = ent_op2_tag[i*TAG_W +: TAG_W];
      end
      cdb_hit1[i] = strobe_en && cdb_valid && src_valid[i] && !src_op1_valid[i]
                    && (src_op1_tag[i] == cdb_tag);
      cdb_hit2[i] = strobe_en && cdb_valid && src_valid[i] && !src_op2_valid[i]
                    && (src_op2_tag[i] == cdb_tag);
    end
  end

  // Reservation-register strobes derived from the source select and wakeups
  always_comb begin
    ent_updt_cmn          = ent_load | ent_shift;
    ent_updt_op1          = ent_updt_cmn | cdb_hit1;
    ent_updt_op2          = ent_updt_cmn | cdb_hit2;
    ent_updt_op1_from_cdb = cdb_hit1;
    ent_updt_op2_from_cdb = cdb_hit2;
    ent_we                = ent_updt_cmn | ent_updt_op1 | ent_updt_op2;
  end

  // Next occupancy, clamped to 0..DEPTH; flush empties the queue
  always_comb begin
    count_d = count_q;
    if (dispatch_fire && !collapse && (count_q < CNT_W'(DEPTH))) begin
      count_d = count_q + CNT_W'(1);
    end else if (collapse && !dispatch_fire && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
    if (flush) begin
      count_d = '0;
    end
  end

  // Grant FSM next state: latch the oldest ready entry, release on ack
  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d     = GRANT;
          grant_idx_d = sel_idx;
        end
      end
      GRANT: begin
        if (issue_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d     = IDLE;
      grant_idx_d = '0;
    end
  end

  // State, grant index and occupancy registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      grant_idx_q <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_alu_queue_ctrl.sv
// Directed self-checking bench for alu_queue_ctrl (DEPTH 4, TAG_W 6).
module tb_alu_queue_ctrl;

  localparam int DEPTH = 4;
  localparam int TAG_W = 6;

  logic                   clk;
  logic                   rst;
  logic                   flush;
  logic                   dispatch_valid;
  logic [TAG_W-1:0]       dispatch_op1_tag;
  logic [TAG_W-1:0]       dispatch_op2_tag;
  logic                   dispatch_op1_valid;
  logic                   dispatch_op2_valid;
  logic                   dispatch_ready;
  logic [DEPTH-1:0]       ent_valid;
  logic [DEPTH-1:0]       ent_op1_valid;
  logic [DEPTH-1:0]       ent_op2_valid;
  logic [DEPTH-1:0]       ent_ready;
  logic [DEPTH*TAG_W-1:0] ent_op1_tag;
  logic [DEPTH*TAG_W-1:0] ent_op2_tag;
  logic                   cdb_valid;
  logic [TAG_W-1:0]       cdb_tag;
  logic [DEPTH-1:0]       ent_load;
  logic [DEPTH-1:0]       ent_shift;
  logic [DEPTH-1:0]       ent_we;
  logic [DEPTH-1:0]       ent_updt_cmn;
  logic [DEPTH-1:0]       ent_updt_op1;
  logic [DEPTH-1:0]       ent_updt_op1_from_cdb;
  logic [DEPTH-1:0]       ent_updt_op2;
  logic [DEPTH-1:0]       ent_updt_op2_from_cdb;
  logic                   issue_valid;
  logic [1:0]             issue_idx;
  logic                   issue_ack;
  logic [2:0]             count;

  int checks   = 0;
  int failures = 0;

  logic [DEPTH-1:0] occ;

  alu_queue_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .flush                 (flush),
    .dispatch_valid        (dispatch_valid),
    .dispatch_op1_tag      (dispatch_op1_tag),
    .dispatch_op2_tag      (dispatch_op2_tag),
    .dispatch_op1_valid    (dispatch_op1_valid),
    .dispatch_op2_valid    (dispatch_op2_valid),
    .dispatch_ready        (dispatch_ready),
    .ent_valid             (ent_valid),
    .ent_op1_valid         (ent_op1_valid),
    .ent_op2_valid         (ent_op2_valid),
    .ent_ready             (ent_ready),
    .ent_op1_tag           (ent_op1_tag),
    .ent_op2_tag           (ent_op2_tag),
    .cdb_valid             (cdb_valid),
    .cdb_tag               (cdb_tag),
    .ent_load              (ent_load),
    .ent_shift             (ent_shift),
    .ent_we                (ent_we),
    .ent_updt_cmn          (ent_updt_cmn),
    .ent_updt_op1          (ent_updt_op1),
    .ent_updt_op1_from_cdb (ent_updt_op1_from_cdb),
    .ent_updt_op2          (ent_updt_op2),
    .ent_updt_op2_from_cdb (ent_updt_op2_from_cdb),
    .issue_valid           (issue_valid),
    .issue_idx             (issue_idx),
    .issue_ack             (issue_ack),
    .count                 (count)
  );

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [DEPTH-1:0] valid, input logic [DEPTH-1:0] op1v,
                               input logic [DEPTH-1:0] op2v, input logic [DEPTH-1:0] ready);
    ent_valid     = valid;
    ent_op1_valid = op1v;
    ent_op2_valid = op2v;
    ent_ready     = ready;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Linear sequence of directed steps
  initial begin
    rst                = 1'b0;
    flush              = 1'b0;
    dispatch_valid     = 1'b1;
    dispatch_op1_valid = 1'b1;
    dispatch_op2_valid = 1'b1;
    dispatch_op1_tag   = '0;
    dispatch_op2_tag   = '0;
    cdb_valid          = 1'b1;
    cdb_tag            = '0;
    issue_ack          = 1'b1;
    ent_op1_tag        = '0;
    ent_op2_tag        = '0;
    applyStimulus(4'b1111, 4'b0000, 4'b0000, 4'b0000);
    occ = '0;

    // Reset held: outputs idle even with live-looking inputs
    #3;
    checkOutput("rst_issue_valid", issue_valid, 0);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_dispatch_ready", dispatch_ready, 1);
    checkOutput("rst_ent_load", ent_load, 0);
    checkOutput("rst_ent_we", ent_we, 0);
    checkOutput("rst_cdb_op1", ent_updt_op1_from_cdb, 0);

    @(posedge clk);
    #1;
    dispatch_valid = 1'b0;
    cdb_valid      = 1'b0;
    issue_ack      = 1'b0;
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    rst = 1'b1;
    tick();
    checkOutput("post_rst_count", count, 0);

    // Fill the queue with ready instructions
    $display("[TB] fill queue");
    for (int k = 0; k < 4; k++) begin
      dispatch_valid = 1'b1;
      #1;
      checkOutput("fill_dispatch_ready", dispatch_ready, 1);
      checkOutput("fill_load_onehot", ent_load, 32'(1) << k);
      tick();
      checkOutput("fill_count", count, 32'(k + 1));
      checkOutput("fill_issue_valid", issue_valid, (k >= 1) ? 1 : 0);
      occ = occ | DEPTH'(32'(1) << k);
      applyStimulus(occ, occ, occ, occ);
    end
    #1;
    checkOutput("full_dispatch_ready", dispatch_ready, 0);
    checkOutput("full_ent_load", ent_load, 0);
    checkOutput("full_ent_we", ent_we, 0);
    checkOutput("full_issue_idx", issue_idx, 0);

    // Flush while granting a full queue
    flush          = 1'b1;
    dispatch_valid = 1'b0;
    tick();
    checkOutput("flush_count", count, 0);
    checkOutput("flush_issue_valid", issue_valid, 0);
    checkOutput("flush_dispatch_ready", dispatch_ready, 1);
    flush = 1'b0;
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Three waiting entries, only entry 1 ready, then collapse
    $display("[TB] collapse over entry 1");
    dispatch_op1_valid = 1'b0;
    dispatch_op2_valid = 1'b0;
    dispatch_op1_tag   = 6'h01;
    dispatch_op2_tag   = 6'h02;
    occ = '0;
    for (int k = 0; k < 3; k++) begin
      dispatch_valid = 1'b1;
      tick();
      occ = occ | DEPTH'(32'(1) << k);
      applyStimulus(occ, 4'b0000, 4'b0000, 4'b0000);
    end
    dispatch_valid = 1'b0;
    checkOutput("three_count", count, 3);
    ent_op1_tag = {4{6'h01}};
    ent_op2_tag = {4{6'h02}};
    applyStimulus(4'b0111, 4'b0010, 4'b0010, 4'b0010);
    tick();
    checkOutput("grant1_issue_valid", issue_valid, 1);
    checkOutput("grant1_issue_idx", issue_idx, 1);
    tick();
    checkOutput("hold_issue_valid", issue_valid, 1);
    checkOutput("hold_issue_idx", issue_idx, 1);
    issue_ack = 1'b1;
    #1;
    checkOutput("ack1_shift", ent_shift, 4'b1110);
    checkOutput("ack1_load", ent_load, 0);
    checkOutput("ack1_cmn", ent_updt_cmn, 4'b1110);
    checkOutput("ack1_we", ent_we, 4'b1110);
    tick();
    checkOutput("ack1_count", count, 2);
    checkOutput("ack1_issue_valid", issue_valid, 0);
    issue_ack = 1'b0;
    applyStimulus(4'b0011, 4'b0000, 4'b0000, 4'b0000);

    // Dispatch alongside a non-matching broadcast
    $display("[TB] CDB wakeup");
    dispatch_valid     = 1'b1;
    dispatch_op1_valid = 1'b1;
    dispatch_op2_valid = 1'b0;
    dispatch_op1_tag   = 6'h07;
    dispatch_op2_tag   = 6'h15;
    cdb_valid          = 1'b1;
    cdb_tag            = 6'h22;
    #1;
    checkOutput("disp_load", ent_load, 4'b0100);
    checkOutput("disp_cdb_miss", ent_updt_op2_from_cdb, 0);
    checkOutput("disp_we", ent_we, 4'b0100);
    tick();
    checkOutput("disp_count", count, 3);
    dispatch_valid = 1'b0;
    cdb_valid      = 1'b0;
    ent_op2_tag[2*TAG_W +: TAG_W] = 6'h15;
    ent_op2_tag[3*TAG_W +: TAG_W] = 6'h15;
    applyStimulus(4'b0111, 4'b0100, 4'b0000, 4'b0000);

    // Matching broadcast wakes entry 2 op2 in place
    cdb_valid = 1'b1;
    cdb_tag   = 6'h15;
    #1;
    checkOutput("wake_op2_cdb", ent_updt_op2_from_cdb, 4'b0100);
    checkOutput("wake_we", ent_we, 4'b0100);
    checkOutput("wake_updt_op2", ent_updt_op2, 4'b0100);
    checkOutput("wake_updt_op1", ent_updt_op1, 0);
    checkOutput("wake_cmn", ent_updt_cmn, 0);
    tick();
    checkOutput("wake_count", count, 3);
    checkOutput("wake_issue_valid", issue_valid, 0);

    // Same broadcast during a collapse at index 1 hits the shifted-in copy
    cdb_valid = 1'b0;
    applyStimulus(4'b0111, 4'b0110, 4'b0010, 4'b0010);
    tick();
    checkOutput("grant2_issue_idx", issue_idx, 1);
    checkOutput("grant2_issue_valid", issue_valid, 1);
    issue_ack = 1'b1;
    cdb_valid = 1'b1;
    #1;
    checkOutput("shiftwake_shift", ent_shift, 4'b1110);
    checkOutput("shiftwake_op2_cdb", ent_updt_op2_from_cdb, 4'b0010);
    checkOutput("shiftwake_updt_op2", ent_updt_op2, 4'b1110);
    checkOutput("shiftwake_op1_cdb", ent_updt_op1_from_cdb, 0);
    tick();
    checkOutput("shiftwake_count", count, 2);
    issue_ack = 1'b0;
    cdb_valid = 1'b0;
    ent_op2_tag = {4{6'h02}};
    applyStimulus(4'b0011, 4'b0000, 4'b0000, 4'b0000);

    // Ack at index 0 together with a dispatch at count 3
    $display("[TB] ack with dispatch");
    dispatch_valid     = 1'b1;
    dispatch_op2_valid = 1'b1;
    tick();
    checkOutput("ad_count_pre", count, 3);
    dispatch_valid = 1'b0;
    applyStimulus(4'b0111, 4'b0101, 4'b0101, 4'b0001);
    tick();
    checkOutput("ad_issue_idx", issue_idx, 0);
    checkOutput("ad_issue_valid", issue_valid, 1);
    issue_ack      = 1'b1;
    dispatch_valid = 1'b1;
    #1;
    checkOutput("ad_dispatch_ready", dispatch_ready, 1);
    checkOutput("ad_load", ent_load, 4'b0100);
    checkOutput("ad_shift", ent_shift, 4'b1011);
    checkOutput("ad_cmn", ent_updt_cmn, 4'b1111);
    tick();
    checkOutput("ad_count", count, 3);
    checkOutput("ad_issue_valid_drop", issue_valid, 0);
    issue_ack      = 1'b0;
    dispatch_valid = 1'b0;
    applyStimulus(4'b0111, 4'b0000, 4'b0000, 4'b0000);

    // Asynchronous reset in the middle of a grant with live strobes
    $display("[TB] async reset mid-grant");
    ent_op2_tag[2*TAG_W +: TAG_W] = 6'h15;
    applyStimulus(4'b0111, 4'b0101, 4'b0001, 4'b0001);
    tick();
    checkOutput("ar_issue_valid_pre", issue_valid, 1);
    dispatch_valid = 1'b1;
    cdb_valid      = 1'b1;
    cdb_tag        = 6'h15;
    #1;
    checkOutput("ar_load_pre", ent_load, 4'b1000);
    checkOutput("ar_we_pre", ent_we, 4'b1100);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("ar_issue_valid", issue_valid, 0);
    checkOutput("ar_we", ent_we, 0);
    checkOutput("ar_load", ent_load, 0);
    checkOutput("ar_op2_cdb", ent_updt_op2_from_cdb, 0);
    checkOutput("ar_count", count, 0);
    checkOutput("ar_dispatch_ready", dispatch_ready, 1);

    dispatch_valid = 1'b0;
    cdb_valid      = 1'b0;
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick();
    rst = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
